nrsr_frame_seq: RTL and testbench

//  Frame sequencer for the add_nrsr multi-frame accumulation datapath. Sits between the sensor

---
 rtl/nrsr_pkg.sv | 26 ++
 rtl/nrsr_frame_seq_if.sv | 36 +++
 rtl/nrsr_sync_cnt.sv | 60 ++++++
 rtl/nrsr_frame_seq.sv | 153 +++++++++++++++
 tb/tb_nrsr_frame_seq.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/nrsr_pkg.sv
// rtl/nrsr_pkg.sv - shared state type, pixel constants and add_num clamp for the nrsr frame sequencer
package nrsr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        ACCUM = 2'd2
    } nrsr_state_t;

    localparam int NRSR_WORD_PIX = 4;
    localparam int NRSR_PIX_W    = 14;

    // A zero request still means one frame; anything above the datapath depth is capped.
    function automatic logic [3:0] nrsr_clamp_add(input logic [3:0] num, input int max_add);
        logic [3:0] res;
        if (num == 4'd0) begin
            res = 4'd1;
        end else if (int'(num) > max_add) begin
            res = 4'(max_add);
        end else begin
            res = num;
        end
        return res;
    endfunction

endpackage

// File: rtl/nrsr_frame_seq_if.sv
// rtl/nrsr_frame_seq_if.sv - sensor timing, config and accumulator control bundle of nrsr_frame_seq
interface nrsr_frame_seq_if #(
    parameter int XW = 12,
    parameter int YW = 12
);
    logic          sens_h_start_in;
    logic          sens_v_start_in;
    logic          sens_h_blank_in;
    logic          sens_v_blank_in;
    logic          cfg_enable;
    logic [3:0]    cfg_add_num;
    logic [YW-1:0] cfg_exp_lines;
    logic          cfg_err_clr;
    logic          acc_wr_en;
    logic          acc_first;
    logic          acc_last;
    logic          grp_done;
    logic [2:0]    frame_idx;
    logic [XW-1:0] word_x;
    logic [YW-1:0] line_y;
    logic          busy;
    logic          err_lines;

    modport master (
        output sens_h_start_in, sens_v_start_in, sens_h_blank_in, sens_v_blank_in,
        output cfg_enable, cfg_add_num, cfg_exp_lines, cfg_err_clr,
        input  acc_wr_en, acc_first, acc_last, grp_done, frame_idx, word_x, line_y, busy, err_lines
    );

    modport slave (
        input  sens_h_start_in, sens_v_start_in, sens_h_blank_in, sens_v_blank_in,
        input  cfg_enable, cfg_add_num, cfg_exp_lines, cfg_err_clr,
        output acc_wr_en, acc_first, acc_last, grp_done, frame_idx, word_x, line_y, busy, err_lines
    );

endinterface

// File: rtl/nrsr_sync_cnt.sv
// rtl/nrsr_sync_cnt.sv - sensor timing decode: active word, v_blank rise, word/line counters
module nrsr_sync_cnt #(
    parameter int XW = 12,
    parameter int YW = 12
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          h_start_i,
    input  logic          v_start_i,
    input  logic          h_blank_i,
    input  logic          v_blank_i,
    output logic          active_o,
    output logic          v_rise_o,
    output logic [YW-1:0] line_idx_o,
    output logic [XW-1:0] word_x_o,
    output logic [YW-1:0] line_y_o
);

    logic          v_blank_q;
    logic [XW-1:0] x_cnt_q, x_cnt_d, x_idx;
    logic [XW-1:0] word_x_q;
    logic [YW-1:0] line_y_q, y_idx;

    assign active_o = !h_blank_i && !v_blank_i;
    assign v_rise_o = v_blank_i && !v_blank_q;

    // x_idx/y_idx are the indices of the word presented this cycle; the counters hold the next one.
    always_comb begin
        x_idx   = h_start_i ? '0 : x_cnt_q;
        x_cnt_d = x_idx;
        if (active_o && (x_idx != '1)) begin
            x_cnt_d = x_idx + 1'b1;
        end
        y_idx = line_y_q;
        if (v_start_i) begin
            y_idx = '0;
        end else if (h_start_i && (line_y_q != '1)) begin
            y_idx = line_y_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_blank_q <= 1'b0;
            x_cnt_q   <= '0;
            word_x_q  <= '0;
            line_y_q  <= '0;
        end else begin
            v_blank_q <= v_blank_i;
            x_cnt_q   <= x_cnt_d;
            word_x_q  <= x_idx;
            line_y_q  <= y_idx;
        end
    end

    assign line_idx_o = y_idx;
    assign word_x_o   = word_x_q;
    assign line_y_o   = line_y_q;

endmodule

// File: rtl/nrsr_frame_seq.sv
// rtl/nrsr_frame_seq.sv - groups N sensor frames into accumulation groups and drives add_nrsr controls
// Optional line-count check enabled by defining NRSR_SEQ_LINE_CHECK_EN.
module nrsr_frame_seq
    import nrsr_pkg::*;
#(
    parameter int MAX_ADD = 8,
    parameter int XW      = 12,
    parameter int YW      = 12
) (
    input  logic           clk_72m,
    input  logic           xreset,
    nrsr_frame_seq_if.slave bus
);

    logic          active;
    logic          v_rise;
    logic [YW-1:0] line_idx;

    nrsr_sync_cnt #(
        .XW(XW),
        .YW(YW)
    ) u_sync_cnt (
        .clk_i      (clk_72m),
        .rst_ni     (xreset),
        .h_start_i  (bus.sens_h_start_in),
        .v_start_i  (bus.sens_v_start_in),
        .h_blank_i  (bus.sens_h_blank_in),
        .v_blank_i  (bus.sens_v_blank_in),
        .active_o   (active),
        .v_rise_o   (v_rise),
        .line_idx_o (line_idx),
        .word_x_o   (bus.word_x),
        .line_y_o   (bus.line_y)
    );

    nrsr_state_t state_q, state_d;
    logic [3:0]  add_num_q, add_num_d, cap_num;
    logic [2:0]  frame_idx_q, frame_idx_d;
    logic        first_q, first_d;
    logic        last_q, last_d;
    logic        done_q, done_d;
    logic        wr_en_q, wr_en_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic        capture, end_grp;

    assign cap_num = nrsr_clamp_add(bus.cfg_add_num, MAX_ADD);

    always_comb begin
        state_d     = state_q;
        add_num_d   = add_num_q;
        frame_idx_d = frame_idx_q;
        first_d     = first_q;
        last_d      = last_q;
        done_d      = 1'b0;
        capture     = 1'b0;
        end_grp     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cfg_enable) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (bus.sens_v_start_in) begin
                    capture = 1'b1;
                end
            end
            ACCUM: begin
                // A v_start on the last frame means v_blank never came: close the group here.
                if (bus.sens_v_start_in && last_q) begin
                    end_grp = 1'b1;
                    capture = 1'b1;
                end else if (bus.sens_v_start_in) begin
                    frame_idx_d = frame_idx_q + 1'b1;
                    first_d     = 1'b0;
                    last_d      = (({1'b0, frame_idx_q} + 4'd2) == add_num_q);
                end else if (v_rise && last_q) begin
                    end_grp = 1'b1;
                    state_d = bus.cfg_enable ? ARM : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (end_grp) begin
            done_d  = 1'b1;
            first_d = 1'b0;
            last_d  = 1'b0;
        end
        if (capture) begin
            if (bus.cfg_enable) begin
                state_d     = ACCUM;
                add_num_d   = cap_num;
                frame_idx_d = 3'd0;
                first_d     = 1'b1;
                last_d      = (cap_num == 4'd1);
            end else begin
                state_d = IDLE;
            end
        end
        wr_en_d = active && (state_d == ACCUM);
        busy_d  = (state_d != IDLE);
    end

`ifdef NRSR_SEQ_LINE_CHECK_EN
    always_comb begin
        err_d = err_q;
        if (bus.cfg_err_clr) begin
            err_d = 1'b0;
        end
        if ((state_q == ACCUM) && v_rise && ((line_idx + 1'b1) != bus.cfg_exp_lines)) begin
            err_d = 1'b1;
        end
    end
`else
    logic unused_line_check;
    assign unused_line_check = ^{bus.cfg_exp_lines, bus.cfg_err_clr, line_idx};
    assign err_d = 1'b0;
`endif

    always_ff @(posedge clk_72m or negedge xreset) begin
        if (!xreset) begin
            state_q     <= IDLE;
            add_num_q   <= 4'd0;
            frame_idx_q <= 3'd0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            add_num_q   <= add_num_d;
            frame_idx_q <= frame_idx_d;
            first_q     <= first_d;
            last_q      <= last_d;
            done_q      <= done_d;
            wr_en_q     <= wr_en_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign bus.acc_wr_en = wr_en_q;
    assign bus.acc_first = first_q;
    assign bus.acc_last  = last_q;
    assign bus.grp_done  = done_q;
    assign bus.frame_idx = frame_idx_q;
    assign bus.busy      = busy_q;
    assign bus.err_lines = err_q;

endmodule

// File: tb/tb_nrsr_frame_seq.sv
// tb/tb_nrsr_frame_seq.sv - randomized frame stimulus with frame-level reference model and scoreboard
`timescale 1ns/1ps
module tb_nrsr_frame_seq;

    localparam int MAX_ADD = 8;
    localparam int XW      = 4;
    localparam int YW      = 3;
    localparam int XMAX    = (1 << XW) - 1;
    localparam int YMAX    = (1 << YW) - 1;

    logic clk_72m = 1'b0;
    logic xreset;
    always #7 clk_72m = ~clk_72m;

    nrsr_frame_seq_if #(.XW(XW), .YW(YW)) bus ();

    nrsr_frame_seq #(.MAX_ADD(MAX_ADD), .XW(XW), .YW(YW)) dut (
        .clk_72m (clk_72m),
        .xreset  (xreset),
        .bus     (bus)
    );

    typedef struct packed {
        logic [2:0]    idx;
        logic          first;
        logic          last;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } word_t;

    word_t exp_words[$];
    int    exp_done[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    words_seen = 0;

    // frame-level model of the group bookkeeping
    bit in_grp = 0;
    int grp_pos = 0;
    int grp_size = 0;
    int grp_words = 0;
    bit err_exp = 0;
    bit cur_vb = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: DUT output with nothing expected at %0t", name, $time);
    endtask

    function automatic int grp_len(input int n);
        return (n == 0) ? 1 : ((n > MAX_ADD) ? MAX_ADD : n);
    endfunction

    function automatic int lines_seen(input int nl);
        int y;
        y = (nl - 1 > YMAX) ? YMAX : nl - 1;
        return (y + 1) % (YMAX + 1);
    endfunction

    always @(negedge clk_72m) begin
        if (xreset === 1'b1) begin
            if (bus.grp_done) begin
                if (exp_done.size() == 0) unexpected("grp_done");
                else chk("grp_done_words", 32'(words_seen), 32'(exp_done.pop_front()));
                words_seen = 0;
            end
            if (bus.acc_wr_en) begin
                words_seen++;
                if (exp_words.size() == 0) unexpected("acc_wr_en");
                else chk("wr_word", 32'({bus.frame_idx, bus.acc_first, bus.acc_last, bus.word_x, bus.line_y}),
                         32'(exp_words.pop_front()));
            end
        end
    end

    task automatic tick(input int hs, input int vs, input int hb, input int vb);
        bus.sens_h_start_in = (hs != 0);
        bus.sens_v_start_in = (vs != 0);
        bus.sens_h_blank_in = (hb != 0);
        bus.sens_v_blank_in = (vb != 0);
        @(posedge clk_72m);
        #1;
        bus.cfg_err_clr = 1'b0;
    endtask

    task automatic clr_err();
        bus.cfg_err_clr = 1'b1;
        tick(0, 0, 1, cur_vb);
        err_exp = 0;
        chk("err_after_clr", 32'(bus.err_lines), 32'(err_exp));
    endtask

    task automatic send_frame(input int nl, input int nw, input bit has_vb,
                              input int drop_line = -1, input int add_line = -1, input int new_add = 0);
        bit    used;
        word_t wd;
        repeat (3) tick(0, 0, 1, cur_vb);
        if (in_grp && grp_pos == grp_size - 1) begin
            exp_done.push_back(grp_words);
            in_grp = 0;
        end
        used = 0;
        if (in_grp) begin
            grp_pos++;
            used = 1;
        end else if (bus.cfg_enable) begin
            in_grp    = 1;
            grp_size  = grp_len(int'(bus.cfg_add_num));
            grp_pos   = 0;
            grp_words = 0;
            used      = 1;
        end
        for (int l = 0; l < nl; l++) begin
            if (l == drop_line) bus.cfg_enable = 1'b0;
            if (l == add_line) bus.cfg_add_num = 4'(new_add);
            for (int w = 0; w < nw; w++) begin
                if (w > 0 && $urandom_range(3) == 0) tick(0, 0, 1, 0);
                if (used) begin
                    wd.idx   = 3'(grp_pos);
                    wd.first = (grp_pos == 0);
                    wd.last  = (grp_pos == grp_size - 1);
                    wd.x     = XW'((w > XMAX) ? XMAX : w);
                    wd.y     = YW'((l > YMAX) ? YMAX : l);
                    exp_words.push_back(wd);
                    grp_words++;
                end
                tick((w == 0) ? 1 : 0, (w == 0 && l == 0) ? 1 : 0, 0, 0);
            end
            repeat (2) tick(0, 0, 1, 0);
        end
        if (has_vb) begin
            if (in_grp) begin
`ifdef NRSR_SEQ_LINE_CHECK_EN
                if (lines_seen(nl) != int'(bus.cfg_exp_lines)) err_exp = 1;
`endif
                if (grp_pos == grp_size - 1) begin
                    exp_done.push_back(grp_words);
                    in_grp = 0;
                end
            end
            repeat ($urandom_range(7, 4)) tick(0, 0, 1, 1);
            cur_vb = 1;
        end else begin
            cur_vb = 0;
        end
        chk("busy", 32'(bus.busy), 32'(in_grp || bus.cfg_enable));
        chk("err_lines", 32'(bus.err_lines), 32'(err_exp));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        xreset = 1'b0;
        bus.sens_h_start_in = 1'b0;
        bus.sens_v_start_in = 1'b0;
        bus.sens_h_blank_in = 1'b1;
        bus.sens_v_blank_in = 1'b0;
        bus.cfg_enable      = 1'b1;
        bus.cfg_add_num     = 4'd3;
        bus.cfg_exp_lines   = YW'(4);
        bus.cfg_err_clr     = 1'b0;
        @(posedge clk_72m);
        #1;

        repeat (16) begin
            tick(int'($urandom_range(1)), int'($urandom_range(1)), int'($urandom_range(1)), int'($urandom_range(1)));
            chk("reset_outputs", 32'({bus.acc_wr_en, bus.acc_first, bus.acc_last, bus.grp_done, bus.busy,
                                      bus.err_lines, bus.frame_idx, bus.word_x, bus.line_y}), 32'd0);
        end

        // release in the middle of a frame: no writes until the next v_start
        xreset = 1'b1;
        for (int l = 0; l < 2; l++) begin
            for (int w = 0; w < 5; w++) tick((w == 0) ? 1 : 0, 0, 0, 0);
            repeat (2) tick(0, 0, 1, 0);
        end
        repeat (5) tick(0, 0, 1, 1);
        cur_vb = 1;
        chk("busy_after_release", 32'(bus.busy), 32'd1);

        // three-frame group, 4 lines x 8 words
        repeat (3) send_frame(4, 8, 1);

        bus.cfg_add_num = 4'd0;
        repeat (2) send_frame(2, 3, 1);
        bus.cfg_add_num = 4'd15;
        repeat (8) send_frame(2, 2, 1);

        // enable dropped inside frame 1 of a 3-frame group
        bus.cfg_add_num = 4'd3;
        send_frame(2, 3, 1);
        send_frame(3, 3, 1, 1);
        send_frame(2, 3, 1);
        send_frame(2, 3, 1);

        // add_num change mid-group takes effect on the next group only
        bus.cfg_enable  = 1'b1;
        bus.cfg_add_num = 4'd2;
        send_frame(3, 3, 1, -1, 1, 4);
        repeat (5) send_frame(2, 3, 1);

        // missing v_blank on the last frame of a group
        bus.cfg_add_num = 4'd2;
        send_frame(2, 3, 1);
        send_frame(2, 3, 0);
        send_frame(2, 3, 1);
        send_frame(2, 3, 1);

        // counter saturation
        bus.cfg_add_num = 4'd1;
        send_frame(9, 18, 1);

        bus.cfg_exp_lines = YW'(3);
        for (int f = 0; f < 14; f++) begin
            bus.cfg_enable  = ($urandom_range(3) != 0);
            bus.cfg_add_num = 4'($urandom_range(15));
            send_frame(int'($urandom_range(4, 1)), int'($urandom_range(6, 1)), ($urandom_range(5) != 0));
        end

        // line-count check: a 3-line frame against 4 expected lines
        bus.cfg_enable  = 1'b1;
        bus.cfg_add_num = 4'd1;
        send_frame(2, 2, 1);
        send_frame(2, 2, 1);
        clr_err();
        bus.cfg_exp_lines = YW'(4);
        send_frame(3, 4, 1);
        clr_err();
        send_frame(4, 4, 1);

        bus.cfg_enable = 1'b0;
        send_frame(2, 2, 1);
        send_frame(2, 2, 1);
        repeat (4) tick(0, 0, 1, cur_vb);
        chk("words_drained", 32'(exp_words.size()), 32'd0);
        chk("done_drained", 32'(exp_done.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
